// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, one-entry stall buffer,
// flush/redirect, HALT detection and a sticky fetch-timeout flag.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000,
    parameter logic [7:0]  TIMEOUT     = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    output logic        halted,
    output logic        err_fetch
);

    typedef enum logic [1:0] {
        BUSY   = 2'd0,
        DRAIN  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] drain_addr;
    logic [15:0] buf_instr;
    logic [15:0] buf_pc2;
    logic [7:0]  wait_cnt;
    logic        data_is_halt;
    logic        buf_is_halt;

    assign pc_inc       = pc + 16'd2;
    assign data_is_halt = (imem_data[15:11] == HALT_OPCODE);
    assign buf_is_halt  = (buf_instr[15:11] == HALT_OPCODE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BUSY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        if (flush) begin
            case (state)
                BUSY, DRAIN: state_next = imem_done ? BUSY : DRAIN;
                default:     state_next = BUSY;
            endcase
        end else begin
            case (state)
                BUSY: begin
                    if (imem_done) begin
                        if (stall) begin
                            state_next = HOLD;
                        end else if (data_is_halt) begin
                            state_next = HALTED;
                        end else begin
                            state_next = BUSY;
                        end
                    end
                end
                DRAIN: begin
                    if (imem_done) begin
                        state_next = BUSY;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_next = buf_is_halt ? HALTED : BUSY;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // A draining request keeps presenting its original address even though pc
    // already points at the redirect target.
    always_comb begin
        imem_rd   = 1'b0;
        imem_addr = pc;
        halted    = 1'b0;
        case (state)
            BUSY:   imem_rd = 1'b1;
            DRAIN: begin
                imem_rd   = 1'b1;
                imem_addr = drain_addr;
            end
            HALTED: halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            instr       <= NOP_INSTR;
            pc_plus2    <= 16'd0;
            instr_valid <= 1'b0;
            buf_instr   <= NOP_INSTR;
            buf_pc2     <= 16'd0;
        end else if (flush) begin
            instr       <= NOP_INSTR;
            pc_plus2    <= 16'd0;
            instr_valid <= 1'b0;
            pc          <= redirect_pc;
            if (state == BUSY && !imem_done) begin
                drain_addr <= pc;
            end
        end else begin
            case (state)
                BUSY: begin
                    if (imem_done) begin
                        pc <= pc_inc;
                        if (stall) begin
                            buf_instr <= imem_data;
                            buf_pc2   <= pc_inc;
                        end else begin
                            instr       <= imem_data;
                            pc_plus2    <= pc_inc;
                            instr_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr       <= buf_instr;
                        pc_plus2    <= buf_pc2;
                        instr_valid <= 1'b1;
                    end
                end
                default: begin
                    if (!stall) begin
                        instr       <= NOP_INSTR;
                        instr_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Counts saturate at TIMEOUT; the error flag stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 8'd0;
            err_fetch <= 1'b0;
        end else if (flush || imem_done || !imem_rd) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != TIMEOUT) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == TIMEOUT - 8'd1) begin
                err_fetch <= 1'b1;
            end
        end
    end

endmodule
